cubic_interp_engine: RTL and testbench

Parametrised successor to the fixed 8-bit cubic engine: it computes one 1-D interpolated sample from four neighbour samples P(-1), P(0), P(1), P(2) and a fractional position t. The block derives t², t³ internally and uses an exact unity term. It supports Catmull-Rom cubic and linear modes and uses valid/ready handshakes on both sides instead of an external cycle counter. It sits between the sample-fetch stage and the output writer of the image scaler; separable 2-D scaling instantiates it per axis.

---
 rtl/cubic_interp_pkg.sv | 55 +++++
 rtl/cubic_weight_gen.sv | 38 +++
 rtl/cubic_interp_engine.sv | 125 ++++++++++++
 tb/tb_cubic_interp_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cubic_interp_pkg.sv
// rtl/cubic_interp_pkg.sv - shared encodings, coefficient tables and width helpers for the cubic interpolator
package cubic_interp_pkg;

    localparam logic MODE_CUBIC  = 1'b0;
    localparam logic MODE_LINEAR = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_POW2 = 3'd1;
    localparam logic [2:0] ST_POW3 = 3'd2;
    localparam logic [2:0] ST_WGT  = 3'd3;
    localparam logic [2:0] ST_DOT  = 3'd4;
    localparam logic [2:0] ST_HOLD = 3'd5;

    // Rows w(-1), w0, w1, w2; columns t3, t2, t, unity. Weights are in half-units.
    localparam int CUBIC_COEF [4][4] = '{
        '{-1,  2, -1, 0},
        '{ 3, -5,  0, 2},
        '{-3,  4,  1, 0},
        '{ 1, -1,  0, 0}
    };
    localparam int LINEAR_COEF [4][4] = '{
        '{0, 0,  0, 0},
        '{0, 0, -2, 2},
        '{0, 0,  2, 0},
        '{0, 0,  0, 0}
    };

    function automatic int weight_w(input int frac_w);
        return frac_w + 5;
    endfunction

    function automatic int acc_w(input int data_w, input int frac_w);
        return frac_w + data_w + 8;
    endfunction

    // Multiply by a small constant coefficient using only shifts and adds.
    function automatic logic signed [31:0] csa(input logic signed [31:0] x, input int c);
        logic signed [31:0] r;
        case (c)
            1:       r = x;
            -1:      r = -x;
            2:       r = x <<< 1;
            -2:      r = -(x <<< 1);
            3:       r = (x <<< 1) + x;
            -3:      r = -((x <<< 1) + x);
            4:       r = x <<< 2;
            -4:      r = -(x <<< 2);
            5:       r = (x <<< 2) + x;
            -5:      r = -((x <<< 2) + x);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cubic_weight_gen.sv
// rtl/cubic_weight_gen.sv - combinational Catmull-Rom / linear weight generator
module cubic_weight_gen
    import cubic_interp_pkg::*;
#(
    parameter int FRAC_W = 8,
    localparam int WW = weight_w(FRAC_W)
) (
    input  logic                 mode,
    input  logic [FRAC_W-1:0]    t,
    input  logic [FRAC_W-1:0]    t2,
    input  logic [FRAC_W-1:0]    t3,
    output logic signed [WW-1:0] w [4]
);

    logic signed [31:0] x [4];
    logic signed [31:0] wc;
    logic signed [31:0] wl;

    assign x[0] = $signed(32'(t3));
    assign x[1] = $signed(32'(t2));
    assign x[2] = $signed(32'(t));
    assign x[3] = 32'sd1 <<< FRAC_W;

    always_comb begin
        wc = '0;
        wl = '0;
        for (int k = 0; k < 4; k++) begin
            wc = '0;
            wl = '0;
            for (int j = 0; j < 4; j++) begin
                wc = wc + csa(x[j], CUBIC_COEF[k][j]);
                wl = wl + csa(x[j], LINEAR_COEF[k][j]);
            end
            w[k] = (mode == MODE_LINEAR) ? WW'(wl) : WW'(wc);
        end
    end

endmodule

// File: rtl/cubic_interp_engine.sv
// rtl/cubic_interp_engine.sv - multi-cycle 1-D cubic/linear interpolator with valid/ready handshakes
module cubic_interp_engine
    import cubic_interp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [FRAC_W-1:0]     in_t,
    input  logic [4*DATA_W-1:0]   in_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data
);

    localparam int WW = weight_w(FRAC_W);
    localparam int AW = acc_w(DATA_W, FRAC_W);
    localparam logic [2*FRAC_W-1:0] POW_HALF = (2*FRAC_W)'(1) << (FRAC_W - 1);
    localparam logic signed [AW-1:0] ACC_HALF = AW'(1) <<< FRAC_W;
    localparam logic signed [AW-1:0] Y_MAX    = AW'((1 << DATA_W) - 1);

    logic [2:0]             state;
    logic                   mode_r;
    logic [FRAC_W-1:0]      t_r;
    logic [FRAC_W-1:0]      t2_r;
    logic [FRAC_W-1:0]      t3_r;
    logic [4*DATA_W-1:0]    p_r;
    logic signed [WW-1:0]   w_r [4];
    logic signed [WW-1:0]   w_c [4];

    logic [FRAC_W-1:0]      mul_a;
    logic [2*FRAC_W-1:0]    pow_sum;
    logic [FRAC_W-1:0]      pow_res;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   y_rnd;
    logic [DATA_W-1:0]      y_clamp;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

    // One multiplier serves both powers: t*t in POW2, t2*t in POW3.
    assign mul_a   = (state == ST_POW3) ? t2_r : t_r;
    assign pow_sum = (mul_a * t_r) + POW_HALF;
    assign pow_res = FRAC_W'(pow_sum >> FRAC_W);

    cubic_weight_gen #(
        .FRAC_W (FRAC_W)
    ) u_weight_gen (
        .mode (mode_r),
        .t    (t_r),
        .t2   (t2_r),
        .t3   (t3_r),
        .w    (w_c)
    );

    always_comb begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc + AW'(w_r[k]) * $signed(AW'({1'b0, p_r[k*DATA_W +: DATA_W]}));
        end
        y_rnd = (acc + ACC_HALF) >>> (FRAC_W + 1);
        if (y_rnd < 0) begin
            y_clamp = '0;
        end else if (y_rnd > Y_MAX) begin
            y_clamp = '1;
        end else begin
            y_clamp = DATA_W'(y_rnd);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_CUBIC;
            t_r      <= '0;
            t2_r     <= '0;
            t3_r     <= '0;
            p_r      <= '0;
            out_data <= '0;
            for (int k = 0; k < 4; k++) begin
                w_r[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_r <= in_mode;
                        t_r    <= in_t;
                        p_r    <= in_p;
                        state  <= ST_POW2;
                    end
                end
                ST_POW2: begin
                    t2_r  <= pow_res;
                    state <= ST_POW3;
                end
                ST_POW3: begin
                    t3_r  <= pow_res;
                    state <= ST_WGT;
                end
                ST_WGT: begin
                    for (int k = 0; k < 4; k++) begin
                        w_r[k] <= w_c[k];
                    end
                    state <= ST_DOT;
                end
                ST_DOT: begin
                    out_data <= y_clamp;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cubic_interp_engine.sv
// tb/tb_cubic_interp_engine.sv - scoreboard bench for cubic_interp_engine (8/8 directed, 10/6 random)
module tb_cubic_interp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
    logic [7:0]  a_in_t;
    logic [31:0] a_in_p;
    logic [7:0]  a_out_data;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
    logic [5:0]  b_in_t;
    logic [39:0] b_in_p;
    logic [9:0]  b_out_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int q_a[$];
    int q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    cubic_interp_engine #(.DATA_W(8), .FRAC_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
        .in_t(a_in_t), .in_p(a_in_p),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    cubic_interp_engine #(.DATA_W(10), .FRAC_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_t(b_in_t), .in_p(b_in_p),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    // Fixed-point reference: weights in half-units, round half-up, clamp.
    function automatic int model(input int dw, input int fw, input bit mode, input int t,
                                 input int pm1, input int p0, input int p1, input int p2);
        int one, t2, t3, wm, w0, w1, w2, acc, y;
        one = 1 << fw;
        t2  = (t * t + (1 << (fw - 1))) >> fw;
        t3  = (t2 * t + (1 << (fw - 1))) >> fw;
        if (!mode) begin
            wm = -t3 + 2 * t2 - t;
            w0 = 3 * t3 - 5 * t2 + 2 * one;
            w1 = -3 * t3 + 4 * t2 + t;
            w2 = t3 - t2;
        end else begin
            wm = 0;
            w0 = 2 * one - 2 * t;
            w1 = 2 * t;
            w2 = 0;
        end
        acc = wm * pm1 + w0 * p0 + w1 * p1 + w2 * p2;
        y = (acc + one) >>> (fw + 1);
        if (y < 0) y = 0;
        if (y > (1 << dw) - 1) y = (1 << dw) - 1;
        return y;
    endfunction

    task automatic drive_a(input bit mode, input int t, input int pm1, input int p0,
                           input int p1, input int p2, output int acc_cyc);
        int n = 0;
        a_in_mode  = mode;
        a_in_t     = 8'(t);
        a_in_p     = {8'(p2), 8'(p1), 8'(p0), 8'(pm1)};
        a_in_valid = 1'b1;
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL a_accept_timeout: in_ready=%0b required 1", a_in_ready);
        end
        @(negedge clk);
        acc_cyc    = cyc;
        a_in_valid = 1'b0;
    endtask

    task automatic collect_a(input string name, input int exp_lat);
        int n = 0;
        int exp_v;
        while (!a_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, n, exp_lat);
        end
        exp_v = (q_a.size() > 0) ? q_a.pop_front() : -1;
        n_cmp++;
        if (a_out_valid !== 1'b1 || int'(a_out_data) !== exp_v) begin
            n_bad++;
            $display("FAIL %s_data: out_valid=%0b out_data=%0d required %0d", name, a_out_valid, a_out_data, exp_v);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic drive_b(input bit mode, input int t, input int pm1, input int p0,
                           input int p1, input int p2);
        int n = 0;
        b_in_mode  = mode;
        b_in_t     = 6'(t);
        b_in_p     = {10'(p2), 10'(p1), 10'(p0), 10'(pm1)};
        b_in_valid = 1'b1;
        while (!b_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (b_in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_accept_timeout: in_ready=%0b required 1", b_in_ready);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp += 5;
        if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %0b required 0", a_out_valid); end
        if (a_out_data !== 8'd0)  begin n_bad++; $display("FAIL reset_a_out_data: got %0d required 0", a_out_data); end
        if (a_in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_a_in_ready: got %0b required 1", a_in_ready); end
        if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid: got %0b required 0", b_out_valid); end
        if (b_in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_b_in_ready: got %0b required 1", b_in_ready); end
    endtask

    task automatic test_directed();
        int c;
        q_a.push_back(255); drive_a(1'b0, 128, 0, 255, 255, 0, c);   collect_a("cubic_overshoot", 4);
        q_a.push_back(0);   drive_a(1'b0, 128, 255, 0, 0, 255, c);   collect_a("cubic_undershoot", 4);
        q_a.push_back(77);  drive_a(1'b0, 0, 200, 77, 13, 250, c);   collect_a("cubic_t0", 4);
        q_a.push_back(77);  drive_a(1'b1, 0, 200, 77, 13, 250, c);   collect_a("linear_t0", 4);
        q_a.push_back(125); drive_a(1'b1, 64, 255, 100, 200, 255, c); collect_a("linear_t64", 4);
        q_a.push_back(100); drive_a(1'b0, 255, 100, 100, 100, 100, c); collect_a("cubic_tmax_flat", 4);
        q_a.push_back(model(8, 8, 1'b0, 255, 10, 40, 250, 30));
        drive_a(1'b0, 255, 10, 40, 250, 30, c); collect_a("cubic_tmax", 4);
    endtask

    task automatic test_backpressure();
        int c;
        int n = 0;
        q_a.push_back(90);
        drive_a(1'b0, 0, 5, 90, 6, 7, c);
        while (!a_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        q_a.push_back(33);
        a_in_mode  = 1'b1;
        a_in_t     = 8'd0;
        a_in_p     = {8'd1, 8'd2, 8'd33, 8'd4};
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp += 3;
            if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %0b required 1", a_out_valid); end
            if (a_out_data !== 8'd90) begin n_bad++; $display("FAIL bp_hold_data: got %0d required 90", a_out_data); end
            if (a_in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_hold_in_ready: got %0b required 0", a_in_ready); end
            @(negedge clk);
        end
        c = (q_a.size() > 0) ? q_a.pop_front() : -1;
        n_cmp++;
        if (a_out_valid !== 1'b1 || int'(a_out_data) !== c) begin
            n_bad++;
            $display("FAIL bp_first_data: out_data=%0d required %0d", a_out_data, c);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %0b required 1", a_in_ready); end
        @(negedge clk);
        a_in_valid = 1'b0;
        collect_a("bp_second", 4);
    endtask

    task automatic test_reset_mid();
        int c;
        int hits = 0;
        drive_a(1'b0, 128, 0, 255, 255, 0, c);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %0b required 0", a_out_valid); end
        if (a_out_data !== 8'd0)  begin n_bad++; $display("FAIL rstmid_out_data: got %0d required 0", a_out_data); end
        if (a_in_ready !== 1'b1)  begin n_bad++; $display("FAIL rstmid_in_ready: got %0b required 1", a_in_ready); end
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (a_out_valid) hits++;
        end
        a_out_ready = 1'b0;
        n_cmp++;
        if (hits !== 0) begin n_bad++; $display("FAIL rstmid_no_result: got %0d results required 0", hits); end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        int got = 0;
        int n = 0;
        int exp_v;
        q_a.push_back(255);
        q_a.push_back(77);
        a_out_ready = 1'b1;
        fork
            begin
                drive_a(1'b0, 128, 0, 255, 255, 0, c1);
                drive_a(1'b0, 0, 9, 77, 9, 9, c2);
            end
            begin
                while (got < 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (a_out_valid) begin
                        exp_v = (q_a.size() > 0) ? q_a.pop_front() : -1;
                        n_cmp++;
                        if (int'(a_out_data) !== exp_v) begin
                            n_bad++;
                            $display("FAIL b2b_data: got %0d required %0d", a_out_data, exp_v);
                        end
                        got++;
                    end
                end
            end
        join
        a_out_ready = 1'b0;
        n_cmp += 2;
        if (got !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d results required 2", got); end
        if (c2 - c1 !== 6) begin n_bad++; $display("FAIL b2b_spacing: got %0d cycles required 6", c2 - c1); end
    endtask

    task automatic test_random_b(input int n_req);
        int got = 0;
        int n = 0;
        int exp_v;
        fork
            begin
                for (int i = 0; i < n_req; i++) begin
                    bit m;
                    int t, p[4];
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    m = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 7))
                        0:       t = 0;
                        1:       t = 63;
                        default: t = int'($urandom_range(0, 63));
                    endcase
                    for (int k = 0; k < 4; k++) begin
                        case ($urandom_range(0, 5))
                            0:       p[k] = 0;
                            1:       p[k] = 1023;
                            default: p[k] = int'($urandom_range(0, 1023));
                        endcase
                    end
                    q_b.push_back(model(10, 6, m, t, p[0], p[1], p[2], p[3]));
                    drive_b(m, t, p[0], p[1], p[2], p[3]);
                end
            end
            begin
                while (got < n_req && n < n_req * 40) begin
                    @(negedge clk);
                    n++;
                    b_out_ready = 1'($urandom_range(0, 1));
                    if (b_out_valid && b_out_ready) begin
                        exp_v = (q_b.size() > 0) ? q_b.pop_front() : -1;
                        n_cmp++;
                        if (int'(b_out_data) !== exp_v) begin
                            n_bad++;
                            $display("FAIL rand_b_data #%0d: got %0d required %0d", got, b_out_data, exp_v);
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        b_out_ready = 1'b0;
        n_cmp += 2;
        if (got !== n_req) begin n_bad++; $display("FAIL rand_b_count: got %0d results required %0d", got, n_req); end
        if (q_b.size() !== 0) begin n_bad++; $display("FAIL rand_b_leftover: got %0d pending required 0", q_b.size()); end
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_mode = 1'b0; a_in_t = '0; a_in_p = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_mode = 1'b0; b_in_t = '0; b_in_p = '0; b_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_b(2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
